pool_bias_act_unit: RTL and testbench
=====================================

Name: pool_bias_act_unit

Overview:
- Post-processing stage between the MAC array and downstream CNN/LSTM consumers.
- CNN path: pools up to POOL_NUM lanes per cycle over a multi-cycle window (MAX or signed AVG), optionally adds bias and applies ReLU, then emits one scalar per window.
- LSTM path: adds bias per lane and forwards the four gate pre-activations (f, i, c, o).

Parameters:
- DIV_WID, 16 (CNN_XLEN): data/divider width in bits; also the number of divider pipeline stages.
- POOL_NUM, 4: lanes per input packet.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- pk_in  input  PBA_IN_PACKET  per-cycle command/data packet.
- pk_out  output  RELU_PACKET  CNN result: act_state, data[DIV_WID].
- lstm_pk  output  LSTM_PACKET  LSTM result: LSTM_state, data_f, data_i, data_c, data_o (each DIV_WID).

Behaviour:
- Reset: all accumulators, pipeline valids and output registers clear; pk_out.act_state=INVALID; lstm_pk.LSTM_state=INVALID; all data fields 0.
- Data format: all data, bias and results are DIV_WID-bit two's complement.
- pool_state encodings: INVALID, VALID, FINISH, COMPL.
- Pool mode (if_pool=1, if_LSTM=0): lanes with valid[k]=1 join the window.
  - MAX: running signed max.
  - AVG: running sum in a DIV_WID+8-bit accumulator.
  - VALID accumulates only.
  - FINISH or COMPL includes the current lanes, closes the window, pushes the result into the divide pipeline, and clears the accumulator in the same cycle.
  - INVALID or if_pool=0 leaves the accumulator untouched.
- Empty window (no valid lane seen, including FINISH with valid=0000): nothing is emitted; the accumulator clears.
- Divide: AVG result = sum / AVG_NUM, where AVG_NUM is sampled on the closing cycle.
  - Truncate toward zero; saturate to DIV_WID bits.
  - AVG_NUM=0 is treated as 1.
  - MAX results traverse the same pipeline with divisor 1, which preserves ordering.
  - Fully pipelined over DIV_WID stages; throughput one result per cycle.
- Pass-through (if_pool=0, if_LSTM=0, pool_state=VALID): data[0] enters the same pipeline as a single result with divisor 1.
- Post-stage, one register:
  - if_bias=1 adds bias[0].
  - if_act=1 applies ReLU (negative values become 0).
- Latency: closing cycle N produces pk_out at cycle N+DIV_WID+2.
- pk_out.act_state: VALID for one cycle per result, or COMPL when the window closed with COMPL (marks layer end); otherwise INVALID.
- LSTM mode (if_LSTM=1): pooling is bypassed and the accumulator is untouched.
  - lane0→f, 1→i, 2→c, 3→o, each plus bias[k] when if_bias=1; no activation.
  - Registered output with 1-cycle latency; LSTM_state=VALID for one cycle.
- Simultaneous LSTM and CNN traffic is legal; the two paths are independent.
- Reset mid-window or mid-pipeline discards all in-flight results.

Optional Feature:
- PBA_SAT_EN defined: bias additions (both paths) saturate to the signed DIV_WID range.
- PBA_SAT_EN undefined: bias additions wrap modulo 2^DIV_WID.
- Divide saturation applies in both builds.

Decomposition:
- Shared package holds:
  - pool_state enum (INVALID, VALID, FINISH, COMPL) and pool_op_mode enum (MAX, AVG).
  - PBA_IN_PACKET: if_pool, if_bias, if_act, if_LSTM, pool_state, pool_op_mode, data[POOL_NUM], bias[POOL_NUM], valid[POOL_NUM], AVG_NUM.
  - RELU_PACKET and LSTM_PACKET.
  - CNN_XLEN and POOL_NUM macros.
- One sub-module: pba_pipe_divider (signed pipelined restoring divider carrying a tag of state/if_bias/if_act/bias0).

Test Plan:
- MAX: FINISH, data 11/12/13/14, valid 1111 → data=14, act_state VALID at +DIV_WID+2; valid 0111 → 13; 0011 → 12.
- COMPL, valid 0001, data 11 → data=11, act_state COMPL; following FINISH with valid 0000 → no output.
- MAX window: VALID (11,12,13,14), VALID (18,15,16,17), FINISH (19,22,20,21) → single result 22.
- AVG window: valid 0001/0010/0100 then FINISH 1000, data 2,3,3,2, AVG_NUM=10 → 10/10=1. Single FINISH, valid 1111, AVG_NUM=3 → 3 (10/3 truncated).
- AVG with ReLU: data -2,-3,-3,-2, AVG_NUM=10, if_act=1 → -1 → ReLU 0, act_state VALID. Same without if_act → 0xFFFF.
- LSTM: if_LSTM=1, if_bias=1, data 2,3,3,2, bias 1,2,3,4 → next cycle f=3, i=5, c=6, o=6, LSTM_state VALID for one cycle; asserting reset mid-pipeline yields no outputs.

Source files
------------

// File: rtl/pool_bias_act_unit_pkg.sv
// Shared types and helpers for the pool/bias/activation stage.
// PBA_SAT_EN: when defined, bias additions saturate instead of wrapping.
`ifndef CNN_XLEN
`define CNN_XLEN 16
`endif
`ifndef POOL_NUM
`define POOL_NUM 4
`endif

package pool_bias_act_unit_pkg;

    localparam int DIV_WID  = `CNN_XLEN;
    localparam int POOL_NUM = `POOL_NUM;
    localparam int ACC_WID  = DIV_WID + 8;

    typedef enum logic [1:0] {
        INVALID = 2'd0,
        VALID   = 2'd1,
        FINISH  = 2'd2,
        COMPL   = 2'd3
    } pool_state_e;

    typedef enum logic {
        MAX = 1'b0,
        AVG = 1'b1
    } pool_op_mode_e;

    typedef struct packed {
        logic                               if_pool;
        logic                               if_bias;
        logic                               if_act;
        logic                               if_LSTM;
        pool_state_e                        pool_state;
        pool_op_mode_e                      pool_op_mode;
        logic [POOL_NUM-1:0][DIV_WID-1:0]   data;
        logic [POOL_NUM-1:0][DIV_WID-1:0]   bias;
        logic [POOL_NUM-1:0]                valid;
        logic [DIV_WID-1:0]                 AVG_NUM;
    } PBA_IN_PACKET;

    typedef struct packed {
        pool_state_e        act_state;
        logic [DIV_WID-1:0] data;
    } RELU_PACKET;

    typedef struct packed {
        pool_state_e        LSTM_state;
        logic [DIV_WID-1:0] data_f;
        logic [DIV_WID-1:0] data_i;
        logic [DIV_WID-1:0] data_c;
        logic [DIV_WID-1:0] data_o;
    } LSTM_PACKET;

    // Post-stage controls that ride alongside each quotient through the divider.
    typedef struct packed {
        pool_state_e        state;
        logic               if_bias;
        logic               if_act;
        logic [DIV_WID-1:0] bias0;
    } pba_tag_t;

    function automatic logic [DIV_WID-1:0] add_bias(input logic [DIV_WID-1:0] a,
                                                    input logic [DIV_WID-1:0] b);
        logic [DIV_WID:0]   s;
        logic [DIV_WID-1:0] r;
        s = {a[DIV_WID-1], a} + {b[DIV_WID-1], b};
        r = s[DIV_WID-1:0];
`ifdef PBA_SAT_EN
        if (s[DIV_WID] != s[DIV_WID-1]) begin
            r = s[DIV_WID] ? {1'b1, {(DIV_WID-1){1'b0}}} : {1'b0, {(DIV_WID-1){1'b1}}};
        end
`endif
        return r;
    endfunction

endpackage

// File: rtl/pool_bias_act_unit_if.sv
// Packet bundle between the MAC array side and the pool/bias/activation stage.
interface pool_bias_act_unit_if;
    import pool_bias_act_unit_pkg::*;

    PBA_IN_PACKET pk_in;
    RELU_PACKET   pk_out;
    LSTM_PACKET   lstm_pk;

    modport master (output pk_in, input pk_out, input lstm_pk);
    modport slave  (input pk_in, output pk_out, output lstm_pk);
endinterface

// File: rtl/pool_bias_act_unit_pba_pipe_divider.sv
// Signed restoring divider, one quotient bit per stage over DIV_WID stages,
// divisor treated as an unsigned count (0 means 1); quotient saturates to DIV_WID bits.
module pba_pipe_divider
    import pool_bias_act_unit_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_vld,
    input  logic [ACC_WID-1:0] in_dividend,
    input  logic [DIV_WID-1:0] in_divisor,
    input  pba_tag_t           in_tag,
    output logic               out_vld,
    output logic [DIV_WID-1:0] out_quo,
    output pba_tag_t           out_tag
);
    localparam int RW = ACC_WID + DIV_WID;
    localparam int NS = DIV_WID;

    logic [RW-1:0]      rem_in [NS];
    logic [RW-1:0]      trial  [NS];
    logic [RW-1:0]      rem_d  [NS];
    logic [RW-1:0]      rem_q  [NS];
    logic [DIV_WID-1:0] quo_in [NS];
    logic [DIV_WID-1:0] quo_d  [NS];
    logic [DIV_WID-1:0] quo_q  [NS];
    logic [DIV_WID-1:0] dvs_in [NS];
    logic [DIV_WID-1:0] dvs_q  [NS];
    logic               vld_in [NS];
    logic               vld_q  [NS];
    logic               neg_in [NS];
    logic               neg_q  [NS];
    logic               ovf_in [NS];
    logic               ovf_q  [NS];
    pba_tag_t           tag_in [NS];
    pba_tag_t           tag_q  [NS];

    logic [ACC_WID-1:0] mag;
    logic [DIV_WID-1:0] dvs0;
    logic               ovf0;
    logic [DIV_WID-1:0] qm;

    always_comb begin
        mag  = in_dividend[ACC_WID-1] ? (~in_dividend + 1'b1) : in_dividend;
        dvs0 = (in_divisor == '0) ? DIV_WID'(1) : in_divisor;
        // Quotients of 2^DIV_WID or more can only saturate, so detect them up front
        // and let the stages resolve just the low DIV_WID quotient bits.
        ovf0 = {{DIV_WID{1'b0}}, mag} >= ({{ACC_WID{1'b0}}, dvs0} << DIV_WID);

        rem_in[0] = {{DIV_WID{1'b0}}, mag};
        quo_in[0] = '0;
        dvs_in[0] = dvs0;
        vld_in[0] = in_vld;
        neg_in[0] = in_dividend[ACC_WID-1];
        ovf_in[0] = ovf0;
        tag_in[0] = in_tag;
        for (int s = 1; s < NS; s++) begin
            rem_in[s] = rem_q[s-1];
            quo_in[s] = quo_q[s-1];
            dvs_in[s] = dvs_q[s-1];
            vld_in[s] = vld_q[s-1];
            neg_in[s] = neg_q[s-1];
            ovf_in[s] = ovf_q[s-1];
            tag_in[s] = tag_q[s-1];
        end

        for (int s = 0; s < NS; s++) begin
            trial[s] = rem_in[s] - ({{ACC_WID{1'b0}}, dvs_in[s]} << (NS - 1 - s));
            if (trial[s][RW-1]) begin
                rem_d[s] = rem_in[s];
                quo_d[s] = quo_in[s];
            end else begin
                rem_d[s] = trial[s];
                quo_d[s] = quo_in[s] | (DIV_WID'(1) << (NS - 1 - s));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NS; s++) begin
                rem_q[s] <= '0;
                quo_q[s] <= '0;
                dvs_q[s] <= '0;
                vld_q[s] <= 1'b0;
                neg_q[s] <= 1'b0;
                ovf_q[s] <= 1'b0;
                tag_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NS; s++) begin
                rem_q[s] <= rem_d[s];
                quo_q[s] <= quo_d[s];
                dvs_q[s] <= dvs_in[s];
                vld_q[s] <= vld_in[s];
                neg_q[s] <= neg_in[s];
                ovf_q[s] <= ovf_in[s];
                tag_q[s] <= tag_in[s];
            end
        end
    end

    always_comb begin
        qm      = quo_q[NS-1];
        out_vld = vld_q[NS-1];
        out_tag = tag_q[NS-1];
        if (!neg_q[NS-1]) begin
            out_quo = (ovf_q[NS-1] || qm[DIV_WID-1]) ? {1'b0, {(DIV_WID-1){1'b1}}} : qm;
        end else if (ovf_q[NS-1] || (qm > {1'b1, {(DIV_WID-1){1'b0}}})) begin
            out_quo = {1'b1, {(DIV_WID-1){1'b0}}};
        end else begin
            out_quo = ~qm + 1'b1;
        end
    end

endmodule

// File: rtl/pool_bias_act_unit.sv
// CNN pooling (MAX/AVG) -> divider -> bias/ReLU, plus an independent 1-cycle LSTM bias path.
// Bias additions wrap by default and saturate when PBA_SAT_EN is defined.
module pool_bias_act_unit
    import pool_bias_act_unit_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    pool_bias_act_unit_if.slave bus
);
    PBA_IN_PACKET pk;
    assign pk = bus.pk_in;

    logic signed [ACC_WID-1:0] acc_q, acc_d, acc_nxt, lane;
    logic                      seen_q, seen_d, seen_nxt;
    logic                      pool_act, close, passthru;

    logic                      s0_vld_q, s0_vld_d;
    logic [ACC_WID-1:0]        s0_sum_q, s0_sum_d;
    logic [DIV_WID-1:0]        s0_dvs_q, s0_dvs_d;
    pba_tag_t                  s0_tag_q, s0_tag_d;

    logic                      div_vld;
    logic [DIV_WID-1:0]        div_quo;
    pba_tag_t                  div_tag;
    logic [DIV_WID-1:0]        post_val;

    RELU_PACKET                pk_out_q, pk_out_d;
    LSTM_PACKET                lstm_q, lstm_d;

    always_comb begin
        pool_act = pk.if_pool && !pk.if_LSTM && (pk.pool_state != INVALID);
        close    = pool_act && ((pk.pool_state == FINISH) || (pk.pool_state == COMPL));
        passthru = !pk.if_pool && !pk.if_LSTM && (pk.pool_state == VALID);

        acc_nxt  = acc_q;
        seen_nxt = seen_q;
        lane     = '0;
        for (int k = 0; k < POOL_NUM; k++) begin
            if (pk.valid[k]) begin
                lane = {{(ACC_WID-DIV_WID){pk.data[k][DIV_WID-1]}}, pk.data[k]};
                if (pk.pool_op_mode == AVG) begin
                    acc_nxt = acc_nxt + lane;
                end else if (!seen_nxt || (lane > acc_nxt)) begin
                    acc_nxt = lane;
                end
                seen_nxt = 1'b1;
            end
        end

        acc_d  = acc_q;
        seen_d = seen_q;
        if (pool_act) begin
            acc_d  = close ? '0 : acc_nxt;
            seen_d = close ? 1'b0 : seen_nxt;
        end

        // MAX and pass-through use divisor 1 so every result shares one ordered pipe.
        s0_vld_d         = (close && seen_nxt) || passthru;
        s0_sum_d         = passthru ? {{(ACC_WID-DIV_WID){pk.data[0][DIV_WID-1]}}, pk.data[0]}
                                    : acc_nxt;
        s0_dvs_d         = (close && (pk.pool_op_mode == AVG)) ? pk.AVG_NUM : DIV_WID'(1);
        s0_tag_d.state   = (!passthru && (pk.pool_state == COMPL)) ? COMPL : VALID;
        s0_tag_d.if_bias = pk.if_bias;
        s0_tag_d.if_act  = pk.if_act;
        s0_tag_d.bias0   = pk.bias[0];
    end

    pba_pipe_divider u_div (
        .clk         (clk),
        .reset       (reset),
        .in_vld      (s0_vld_q),
        .in_dividend (s0_sum_q),
        .in_divisor  (s0_dvs_q),
        .in_tag      (s0_tag_q),
        .out_vld     (div_vld),
        .out_quo     (div_quo),
        .out_tag     (div_tag)
    );

    always_comb begin
        post_val = div_tag.if_bias ? add_bias(div_quo, div_tag.bias0) : div_quo;
        if (div_tag.if_act && post_val[DIV_WID-1]) begin
            post_val = '0;
        end
        pk_out_d = '0;
        if (div_vld) begin
            pk_out_d.act_state = div_tag.state;
            pk_out_d.data      = post_val;
        end

        lstm_d = '0;
        if (pk.if_LSTM) begin
            lstm_d.LSTM_state = VALID;
            lstm_d.data_f = pk.if_bias ? add_bias(pk.data[0], pk.bias[0]) : pk.data[0];
            lstm_d.data_i = pk.if_bias ? add_bias(pk.data[1], pk.bias[1]) : pk.data[1];
            lstm_d.data_c = pk.if_bias ? add_bias(pk.data[2], pk.bias[2]) : pk.data[2];
            lstm_d.data_o = pk.if_bias ? add_bias(pk.data[3], pk.bias[3]) : pk.data[3];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            seen_q   <= 1'b0;
            s0_vld_q <= 1'b0;
            s0_sum_q <= '0;
            s0_dvs_q <= '0;
            s0_tag_q <= '0;
            pk_out_q <= '0;
            lstm_q   <= '0;
        end else begin
            acc_q    <= acc_d;
            seen_q   <= seen_d;
            s0_vld_q <= s0_vld_d;
            s0_sum_q <= s0_sum_d;
            s0_dvs_q <= s0_dvs_d;
            s0_tag_q <= s0_tag_d;
            pk_out_q <= pk_out_d;
            lstm_q   <= lstm_d;
        end
    end

    assign bus.pk_out  = pk_out_q;
    assign bus.lstm_pk = lstm_q;

endmodule

// File: tb/tb_pool_bias_act_unit.sv
// Directed bench for pool_bias_act_unit: CNN pooling/divide/bias/ReLU, LSTM bias path, reset flush.
module tb_pool_bias_act_unit;
    import pool_bias_act_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail = 0;
    int   out_cnt = 0;
    int   lstm_cnt = 0;
    int   cnt_base = 0;
    int   lstm_base = 0;
    logic [15:0] wrap_exp;
    PBA_IN_PACKET p;

    pool_bias_act_unit_if pbus ();

    pool_bias_act_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (pbus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (pbus.pk_out.act_state != INVALID) out_cnt++;
            if (pbus.lstm_pk.LSTM_state != INVALID) lstm_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic PBA_IN_PACKET pkt(input logic pool, input pool_state_e st,
                                         input pool_op_mode_e md, input logic [3:0] v,
                                         input logic [15:0] d0, input logic [15:0] d1,
                                         input logic [15:0] d2, input logic [15:0] d3,
                                         input logic [15:0] avg);
        PBA_IN_PACKET r;
        r = '0;
        r.if_pool      = pool;
        r.pool_state   = st;
        r.pool_op_mode = md;
        r.valid        = v;
        r.data[0]      = d0;
        r.data[1]      = d1;
        r.data[2]      = d2;
        r.data[3]      = d3;
        r.AVG_NUM      = avg;
        return r;
    endfunction

    task automatic idle();
        pbus.pk_in = '0;
    endtask

    task automatic send(input PBA_IN_PACKET x);
        pbus.pk_in = x;
        @(posedge clk);
        #1;
    endtask

    task automatic mark();
        cnt_base = out_cnt;
    endtask

    // Called right after the closing packet was sampled.
    task automatic expect_cnn(input string tag, input pool_state_e st, input logic [15:0] d);
        idle();
        repeat (DIV_WID) @(posedge clk);
        #1;
        check_val({tag, "_early"}, 32'(pbus.pk_out.act_state), 32'(INVALID));
        @(posedge clk);
        #1;
        check_val({tag, "_state"}, 32'(pbus.pk_out.act_state), 32'(st));
        check_val({tag, "_data"}, 32'(pbus.pk_out.data), 32'(d));
        @(posedge clk);
        #1;
        check_val({tag, "_cnt"}, 32'(out_cnt - cnt_base), 32'd1);
    endtask

    task automatic expect_none(input string tag);
        idle();
        repeat (DIV_WID + 4) @(posedge clk);
        #1;
        check_val({tag, "_cnt"}, 32'(out_cnt - cnt_base), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_act_state", 32'(pbus.pk_out.act_state), 32'(INVALID));
        check_val("rst_data", 32'(pbus.pk_out.data), 32'd0);
        check_val("rst_lstm_state", 32'(pbus.lstm_pk.LSTM_state), 32'(INVALID));
        check_val("rst_lstm_f", 32'(pbus.lstm_pk.data_f), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        mark(); send(pkt(1'b1, FINISH, MAX, 4'b1111, 16'd11, 16'd12, 16'd13, 16'd14, 16'd0));
        expect_cnn("max_1111", VALID, 16'd14);
        mark(); send(pkt(1'b1, FINISH, MAX, 4'b0111, 16'd11, 16'd12, 16'd13, 16'd14, 16'd0));
        expect_cnn("max_0111", VALID, 16'd13);
        mark(); send(pkt(1'b1, FINISH, MAX, 4'b0011, 16'd11, 16'd12, 16'd13, 16'd14, 16'd0));
        expect_cnn("max_0011", VALID, 16'd12);

        mark(); send(pkt(1'b1, COMPL, MAX, 4'b0001, 16'd11, 16'd12, 16'd13, 16'd14, 16'd0));
        expect_cnn("compl", COMPL, 16'd11);
        mark(); send(pkt(1'b1, FINISH, MAX, 4'b0000, 16'd11, 16'd12, 16'd13, 16'd14, 16'd0));
        expect_none("empty");

        mark();
        send(pkt(1'b1, VALID, MAX, 4'b1111, 16'd11, 16'd12, 16'd13, 16'd14, 16'd0));
        send(pkt(1'b1, VALID, MAX, 4'b1111, 16'd18, 16'd15, 16'd16, 16'd17, 16'd0));
        send(pkt(1'b1, FINISH, MAX, 4'b1111, 16'd19, 16'd22, 16'd20, 16'd21, 16'd0));
        expect_cnn("max_win", VALID, 16'd22);

        mark();
        send(pkt(1'b1, VALID, AVG, 4'b0001, 16'd2, 16'd3, 16'd3, 16'd2, 16'd0));
        send(pkt(1'b1, VALID, AVG, 4'b0010, 16'd2, 16'd3, 16'd3, 16'd2, 16'd0));
        send(pkt(1'b1, VALID, AVG, 4'b0100, 16'd2, 16'd3, 16'd3, 16'd2, 16'd0));
        send(pkt(1'b1, FINISH, AVG, 4'b1000, 16'd2, 16'd3, 16'd3, 16'd2, 16'd10));
        expect_cnn("avg_win", VALID, 16'd1);
        mark(); send(pkt(1'b1, FINISH, AVG, 4'b1111, 16'd2, 16'd3, 16'd3, 16'd2, 16'd3));
        expect_cnn("avg_trunc", VALID, 16'd3);

        mark(); p = pkt(1'b1, FINISH, AVG, 4'b1111, 16'hFFFE, 16'hFFFD, 16'hFFFD, 16'hFFFE, 16'd10);
        p.if_act = 1'b1; send(p);
        expect_cnn("avg_relu", VALID, 16'd0);
        mark(); send(pkt(1'b1, FINISH, AVG, 4'b1111, 16'hFFFE, 16'hFFFD, 16'hFFFD, 16'hFFFE, 16'd10));
        expect_cnn("avg_neg", VALID, 16'hFFFF);

        // INVALID cycle with valid lanes must not disturb the running sum: (5+5)/2.
        mark();
        send(pkt(1'b1, VALID, AVG, 4'b0001, 16'd5, 16'd0, 16'd0, 16'd0, 16'd0));
        send(pkt(1'b1, INVALID, AVG, 4'b1111, 16'd100, 16'd100, 16'd100, 16'd100, 16'd0));
        send(pkt(1'b1, FINISH, AVG, 4'b0001, 16'd5, 16'd0, 16'd0, 16'd0, 16'd2));
        expect_cnn("avg_hold", VALID, 16'd5);

        mark(); send(pkt(1'b1, FINISH, AVG, 4'b1111, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'd0));
        expect_cnn("sat_pos_n0", VALID, 16'h7FFF);
        mark(); send(pkt(1'b1, FINISH, AVG, 4'b1111, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'd2));
        expect_cnn("sat_neg", VALID, 16'h8000);

        mark(); p = pkt(1'b1, FINISH, MAX, 4'b1111, 16'd11, 16'd12, 16'd13, 16'd14, 16'd0);
        p.if_bias = 1'b1; p.bias[0] = 16'd5; send(p);
        expect_cnn("max_bias", VALID, 16'd19);
`ifdef PBA_SAT_EN
        wrap_exp = 16'h7FFF;
`else
        wrap_exp = 16'h8000;
`endif
        mark(); p = pkt(1'b1, FINISH, MAX, 4'b0001, 16'h7FFF, 16'd0, 16'd0, 16'd0, 16'd0);
        p.if_bias = 1'b1; p.bias[0] = 16'd1; send(p);
        expect_cnn("bias_ovf", VALID, wrap_exp);

        mark(); p = pkt(1'b0, VALID, MAX, 4'b0000, 16'hFFF9, 16'd0, 16'd0, 16'd0, 16'd0);
        p.if_bias = 1'b1; p.bias[0] = 16'd10; send(p);
        expect_cnn("pass_bias", VALID, 16'd3);

        // LSTM packet while a CNN result is still inside the divider.
        mark(); lstm_base = lstm_cnt;
        send(pkt(1'b1, FINISH, MAX, 4'b1111, 16'd11, 16'd12, 16'd13, 16'd14, 16'd0));
        p = pkt(1'b0, INVALID, MAX, 4'b0000, 16'd2, 16'd3, 16'd3, 16'd2, 16'd0);
        p.if_LSTM = 1'b1; p.if_bias = 1'b1;
        p.bias[0] = 16'd1; p.bias[1] = 16'd2; p.bias[2] = 16'd3; p.bias[3] = 16'd4;
        send(p);
        check_val("lstm_state", 32'(pbus.lstm_pk.LSTM_state), 32'(VALID));
        check_val("lstm_f", 32'(pbus.lstm_pk.data_f), 32'd3);
        check_val("lstm_i", 32'(pbus.lstm_pk.data_i), 32'd5);
        check_val("lstm_c", 32'(pbus.lstm_pk.data_c), 32'd6);
        check_val("lstm_o", 32'(pbus.lstm_pk.data_o), 32'd6);
        idle();
        @(posedge clk);
        #1;
        check_val("lstm_pulse", 32'(pbus.lstm_pk.LSTM_state), 32'(INVALID));
        check_val("lstm_cnt", 32'(lstm_cnt - lstm_base), 32'd1);
        repeat (DIV_WID - 2) @(posedge clk);
        #1;
        check_val("mix_early", 32'(pbus.pk_out.act_state), 32'(INVALID));
        @(posedge clk);
        #1;
        check_val("mix_state", 32'(pbus.pk_out.act_state), 32'(VALID));
        check_val("mix_data", 32'(pbus.pk_out.data), 32'd14);
        @(posedge clk);
        #1;

        // Reset while a CNN result is in flight and an LSTM packet is presented.
        mark(); lstm_base = lstm_cnt;
        send(pkt(1'b1, FINISH, MAX, 4'b1111, 16'd11, 16'd12, 16'd13, 16'd14, 16'd0));
        idle();
        repeat (3) @(posedge clk);
        #1;
        pbus.pk_in = p;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        idle();
        reset = 1'b0;
        repeat (DIV_WID + 4) @(posedge clk);
        #1;
        check_val("rst_flush_cnn", 32'(out_cnt - cnt_base), 32'd0);
        check_val("rst_flush_lstm", 32'(lstm_cnt - lstm_base), 32'd0);
        check_val("rst_flush_state", 32'(pbus.pk_out.act_state), 32'(INVALID));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
